frame_checker_param: RTL and testbench
======================================

// Module: frame_checker_param
// PURPOSE
//  Width-generic receive-side checker for tester test frames (IPv4, TEST_FRAME_PROTO/TOS).
//  Sits between the MAC RX AXIS stream and the router-facing AXIS port:
//  - Consumes and verifies test frames (checksum, LFSR payload, keep shape).
//  - Passes all other frames through unchanged.
//  - Accumulates good/bad frame and byte counters with start/stop/drain control.
// PARAMETERS
//  DATA_WIDTH     512  AXIS data width in bits; power of two, >= 8*HDR_BYTES
//  ID_WIDTH       3    AXIS tid width
//  CNT_WIDTH      64   width of each result counter
//  LEN_WIDTH      16   per-frame byte accumulator width
//  HDR_BYTES      34   first-beat bytes (Ethernet + IPv4) excluded from payload compare
//  MIN_LEN        64   minimum legal test frame bytes (LEN_CHECK only)
//  MAX_LEN        1518 maximum legal test frame bytes (LEN_CHECK only)
// PORTS
//  clk            in   1            clock
//  rst            in   1            synchronous active-high reset
//  start          in   1            clear counters, enter RUN
//  stop           in   1            stop counting after current test frame
//  ready          out  1            1 in IDLE
//  recv_frames    out  CNT_WIDTH    good test frames
//  recv_bytes     out  CNT_WIDTH    bytes in good test frames
//  err_frames     out  CNT_WIDTH    bad test frames
//  err_bytes      out  CNT_WIDTH    bytes in bad test frames
//  axis_s_*       in   std          data/keep/last/user(DATA_WIDTH/8)/id/valid; s_ready out
//  axis_m_*       out  std          same fields; m_ready in
// BEHAVIOUR
//  Reset: ctrl=IDLE, frame=WAIT_FIRST, all counters 0, ready=1, axis_m_valid=0, axis_s_ready=0.
//  Ctrl FSM:
//   - IDLE -start-> RUN.
//   - RUN -stop-> DRAIN if frame==IN_TEST, else IDLE.
//   - DRAIN -> IDLE after the IN_TEST last beat is accepted (that frame is counted).
//   - start in any state: counters <= 0, ctrl <= RUN; wins over stop and over a same-cycle count.
//  Frame FSM (advances only on s handshake):
//   - WAIT_FIRST: beat is test-first when ether_type=0x0800, proto/tos match, ver=4, ihl=5.
//     Test-first -> IN_TEST; non-test -> IN_PASS. last=1 returns to WAIT_FIRST in all cases.
//   - IN_TEST / IN_PASS hold until a last beat.
//   - Single-beat frames classify and finish in one handshake.
//  Pass-through: data/keep/last/user/id combinational s->m.
//   - Non-test beats: m_valid=s_valid, s_ready=m_ready.
//   - Test beats: m_valid=0, s_ready=1 (dropped, never back-pressured).
//  Test-frame checks (frame good iff all pass):
//   - Header checksum equals computed IPv4 checksum.
//   - Payload: LFSR seed = ip id. Beat 0 pattern = id; beat k pattern = step^k(id), with
//     step(l) = {l[0]^l[2]^l[3]^l[5], l[15:1]}.
//   - Pattern replicated across DATA_WIDTH. Compare bytes with keep=1 (beat 0: bytes >= HDR_BYTES).
//   - keep contiguous from byte 0. keep all-ones on non-last beats.
//   - user==0 on every beat.
//  Length: beat bytes = popcount(keep); per-frame sum saturates at 2^LEN_WIDTH-1.
//   - Saturation marks the frame bad.
//  Counting:
//   - Only in RUN/DRAIN, on the test last-beat handshake; counters update the next cycle.
//   - Good: recv_frames+1, recv_bytes+len. Bad: err_frames+1, err_bytes+len.
//   - Counters saturate at all-ones (no wrap).
//   - A test frame whose first beat arrived in IDLE is dropped but never counted.
//  Reset mid-frame: state cleared; the remaining beats of that frame are treated as
//   WAIT_FIRST beats.
// CONFIGURATION
//  FRAME_CHECKER_LEN_CHECK_EN defined:
//   - Frames with len<MIN_LEN or len>MAX_LEN are bad.
//   - After MAX_LEN is exceeded, the frame is consumed silently without further compare.
//  FRAME_CHECKER_LEN_CHECK_EN undefined: no length bound check; MIN_LEN/MAX_LEN unused.
// TESTING
//  1. start; 100-byte good test frame (2 beats @512) -> recv_frames=1, recv_bytes=100;
//     m_valid stays 0.
//  2. Same frame with payload byte 40 flipped -> err_frames=1, err_bytes=100, recv_* = 0.
//  3. Non-test ARP frame with m_ready=0 for 5 cycles -> s_ready=0 for those cycles;
//     beats appear on m unmodified; counters unchanged.
//  4. stop asserted mid test frame -> DRAIN; frame counted at last beat; ready=1 next cycle;
//     a further test frame leaves counters unchanged.
//  5. start on the same cycle as a test last beat -> all counters 0 (start wins); ctrl=RUN.
//  6. LEN_CHECK_EN, 1600-byte valid-pattern frame -> err_frames=1; without the macro -> recv_frames=1.

Source files
------------

// File: rtl/frame_checker_param.sv
// frame_checker_param: checks tester IPv4 test frames on the RX stream, passes others through.
// Define FRAME_CHECKER_LEN_CHECK_EN to enable the MIN_LEN/MAX_LEN bounds on test frames.
module frame_checker_param #(
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH = 3,
  parameter int CNT_WIDTH = 64,
  parameter int LEN_WIDTH = 16,
  parameter int HDR_BYTES = 34,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter logic [7:0] TEST_FRAME_PROTO = 8'hFD,
  parameter logic [7:0] TEST_FRAME_TOS = 8'h5C
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  output logic ready,
  output logic [CNT_WIDTH-1:0] recv_frames,
  output logic [CNT_WIDTH-1:0] recv_bytes,
  output logic [CNT_WIDTH-1:0] err_frames,
  output logic [CNT_WIDTH-1:0] err_bytes,
  input  logic [DATA_WIDTH-1:0] axis_s_data,
  input  logic [DATA_WIDTH/8-1:0] axis_s_keep,
  input  logic axis_s_last,
  input  logic [DATA_WIDTH/8-1:0] axis_s_user,
  input  logic [ID_WIDTH-1:0] axis_s_id,
  input  logic axis_s_valid,
  output logic axis_s_ready,
  output logic [DATA_WIDTH-1:0] axis_m_data,
  output logic [DATA_WIDTH/8-1:0] axis_m_keep,
  output logic axis_m_last,
  output logic [DATA_WIDTH/8-1:0] axis_m_user,
  output logic [ID_WIDTH-1:0] axis_m_id,
  output logic axis_m_valid,
  input  logic axis_m_ready
);

  localparam int KW = DATA_WIDTH / 8;
  localparam int LW1 = LEN_WIDTH + 1;
  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_RUN = 2'd1;
  localparam logic [1:0] C_DRAIN = 2'd2;
  localparam logic [1:0] F_WAIT = 2'd0;
  localparam logic [1:0] F_TEST = 2'd1;
  localparam logic [1:0] F_PASS = 2'd2;
  localparam logic [LEN_WIDTH-1:0] LEN_SAT = '1;
`ifdef FRAME_CHECKER_LEN_CHECK_EN
  localparam logic [LEN_WIDTH-1:0] MIN_L = LEN_WIDTH'(MIN_LEN);
  localparam logic [LEN_WIDTH-1:0] MAX_L = LEN_WIDTH'(MAX_LEN);
  logic len_err;
`endif

  logic [1:0] ctrl;
  logic [1:0] frame;
  logic [LEN_WIDTH-1:0] len_acc;
  logic err_acc;
  logic cnt_en;
  logic [15:0] lfsr;

  logic [7:0] hb [HDR_BYTES];
  logic hdr_test;
  logic first;
  logic test_beat;
  logic hs;
  logic fin;
  logic csum_ok;
  logic pay_err;
  logic shape_err;
  logic user_err;
  logic len_sat;
  logic beat_err;
  logic frame_bad;
  logic count_ok;
  logic do_count;
  logic [15:0] ip_id;
  logic [15:0] pat;
  logic [19:0] csum_acc;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic [LEN_WIDTH:0] beat_len;
  logic [LEN_WIDTH:0] len_sum;
  logic [LEN_WIDTH-1:0] len_tot;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(
    input logic [CNT_WIDTH-1:0] a,
    input logic [CNT_WIDTH-1:0] b
  );
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < HDR_BYTES; i++) begin
      hb[i] = axis_s_data[8*i +: 8];
    end
    hdr_test = (hb[12] == 8'h08) && (hb[13] == 8'h00) &&
               (hb[14] == 8'h45) && (hb[15] == TEST_FRAME_TOS) &&
               (hb[23] == TEST_FRAME_PROTO);
    ip_id = {hb[18], hb[19]};
    // checksum word (bytes 24/25) is summed as zero
    csum_acc = '0;
    for (int j = 0; j < 10; j++) begin
      if (j != 5) begin
        csum_acc = csum_acc + 20'({hb[14+2*j], hb[15+2*j]});
      end
    end
    fold1 = {1'b0, csum_acc[15:0]} + 17'(csum_acc[19:16]);
    fold2 = fold1[15:0] + 16'(fold1[16]);
    csum_ok = (~fold2 == {hb[24], hb[25]});
  end

  assign first = (frame == F_WAIT);
  assign test_beat = first ? hdr_test : (frame == F_TEST);
  assign hs = axis_s_valid && axis_s_ready;
  assign fin = hs && test_beat && axis_s_last;
  assign pat = first ? ip_id : lfsr;

  always_comb begin
    pay_err = 1'b0;
    beat_len = '0;
    for (int i = 0; i < KW; i++) begin
      beat_len = beat_len + LW1'(axis_s_keep[i]);
      if (axis_s_keep[i] && (!first || i >= HDR_BYTES) &&
          (axis_s_data[8*i +: 8] != ((i % 2 == 1) ? pat[15:8] : pat[7:0]))) begin
        pay_err = 1'b1;
      end
    end
    shape_err = !axis_s_keep[0] ||
                ((axis_s_keep & (axis_s_keep + KW'(1))) != '0) ||
                (!axis_s_last && !(&axis_s_keep));
    user_err = |axis_s_user;
    len_sum = {1'b0, len_acc} + beat_len;
    len_sat = (len_sum >= {1'b0, LEN_SAT});
    len_tot = len_sat ? LEN_SAT : len_sum[LEN_WIDTH-1:0];
`ifdef FRAME_CHECKER_LEN_CHECK_EN
    len_err = len_sat || (len_tot > MAX_L) ||
              (axis_s_last && (len_tot < MIN_L));
    // once past MAX_LEN the rest of the frame is only consumed
    beat_err = len_err || ((len_acc <= MAX_L) &&
               (pay_err || shape_err || user_err || (first && !csum_ok)));
`else
    beat_err = len_sat || pay_err || shape_err || user_err ||
               (first && !csum_ok);
`endif
    frame_bad = err_acc || beat_err;
  end

  assign count_ok = first ? (ctrl != C_IDLE) : cnt_en;
  assign do_count = fin && count_ok && (ctrl != C_IDLE);

  assign axis_m_data = axis_s_data;
  assign axis_m_keep = axis_s_keep;
  assign axis_m_last = axis_s_last;
  assign axis_m_user = axis_s_user;
  assign axis_m_id = axis_s_id;
  assign axis_m_valid = !rst && axis_s_valid && !test_beat;
  assign axis_s_ready = !rst && (test_beat || axis_m_ready);
  assign ready = (ctrl == C_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= C_IDLE;
      frame <= F_WAIT;
      len_acc <= '0;
      err_acc <= 1'b0;
      cnt_en <= 1'b0;
      lfsr <= '0;
      recv_frames <= '0;
      recv_bytes <= '0;
      err_frames <= '0;
      err_bytes <= '0;
    end else begin
      if (hs) begin
        if (axis_s_last) begin
          frame <= F_WAIT;
        end else if (first) begin
          frame <= hdr_test ? F_TEST : F_PASS;
        end
        if (test_beat) begin
          lfsr <= lfsr_step(pat);
          if (axis_s_last) begin
            len_acc <= '0;
            err_acc <= 1'b0;
            cnt_en <= 1'b0;
          end else begin
            len_acc <= len_tot;
            err_acc <= frame_bad;
            if (first) begin
              cnt_en <= (ctrl != C_IDLE);
            end
          end
        end
      end

      if (start) begin
        ctrl <= C_RUN;
      end else begin
        unique case (1'b1)
          (ctrl == C_RUN): begin
            if (stop) begin
              ctrl <= (frame == F_TEST && !(hs && axis_s_last)) ?
                      C_DRAIN : C_IDLE;
            end
          end
          (ctrl == C_DRAIN): begin
            if (fin) begin
              ctrl <= C_IDLE;
            end
          end
          default: ;
        endcase
      end

      if (start) begin
        recv_frames <= '0;
        recv_bytes <= '0;
        err_frames <= '0;
        err_bytes <= '0;
      end else if (do_count) begin
        if (frame_bad) begin
          err_frames <= sat_add(err_frames, CNT_WIDTH'(1));
          err_bytes <= sat_add(err_bytes, CNT_WIDTH'(len_tot));
        end else begin
          recv_frames <= sat_add(recv_frames, CNT_WIDTH'(1));
          recv_bytes <= sat_add(recv_bytes, CNT_WIDTH'(len_tot));
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_checker_param.sv
// tb_frame_checker_param: scenario tasks with a pass-through scoreboard
// and bench-side frame/counter models.
module tb_frame_checker_param;
  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int CW = 64;
  localparam logic [7:0] PROTO = 8'hFD;
  localparam logic [7:0] TOS = 8'h5C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic ready;
  logic [CW-1:0] recv_frames, recv_bytes, err_frames, err_bytes;
  logic [DW-1:0] axis_s_data = '0;
  logic [KW-1:0] axis_s_keep = '0;
  logic axis_s_last = 1'b0;
  logic [KW-1:0] axis_s_user = '0;
  logic [2:0] axis_s_id = 3'd5;
  logic axis_s_valid = 1'b0;
  logic axis_s_ready;
  logic [DW-1:0] axis_m_data;
  logic [KW-1:0] axis_m_keep;
  logic axis_m_last;
  logic [KW-1:0] axis_m_user;
  logic [2:0] axis_m_id;
  logic axis_m_valid;
  logic axis_m_ready = 1'b1;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic l;
    logic [KW-1:0] u;
    logic [2:0] id;
  } beat_t;

  beat_t sb [$];
  int checks = 0;
  int errors = 0;
  int m_seen = 0;
  logic [7:0] fb [0:2047];
  logic [KW-1:0] user_inj = '0;
  logic [KW-1:0] last_kmask = '1;
  logic [CW-1:0] e_rf, e_rb, e_ef, e_eb;

  frame_checker_param #(
    .DATA_WIDTH(DW), .ID_WIDTH(3), .CNT_WIDTH(CW), .LEN_WIDTH(16),
    .HDR_BYTES(34), .MIN_LEN(64), .MAX_LEN(1518),
    .TEST_FRAME_PROTO(PROTO), .TEST_FRAME_TOS(TOS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .ready(ready),
    .recv_frames(recv_frames), .recv_bytes(recv_bytes),
    .err_frames(err_frames), .err_bytes(err_bytes),
    .axis_s_data(axis_s_data), .axis_s_keep(axis_s_keep),
    .axis_s_last(axis_s_last), .axis_s_user(axis_s_user),
    .axis_s_id(axis_s_id), .axis_s_valid(axis_s_valid),
    .axis_s_ready(axis_s_ready),
    .axis_m_data(axis_m_data), .axis_m_keep(axis_m_keep),
    .axis_m_last(axis_m_last), .axis_m_user(axis_m_user),
    .axis_m_id(axis_m_id), .axis_m_valid(axis_m_valid),
    .axis_m_ready(axis_m_ready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (axis_m_valid && axis_m_ready) begin
      beat_t e;
      m_seen++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL m_unexpected got data[63:0]=%h last=%b",
                 axis_m_data[63:0], axis_m_last);
      end else begin
        e = sb.pop_front();
        if ({axis_m_data, axis_m_keep, axis_m_last, axis_m_user, axis_m_id}
            !== {e.d, e.k, e.l, e.u, e.id}) begin
          errors++;
          $display("FAIL m_beat got keep=%h last=%b d=%h exp keep=%h last=%b d=%h",
                   axis_m_keep, axis_m_last, axis_m_data[127:0],
                   e.k, e.l, e.d[127:0]);
        end
      end
    end
  end

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    e_rf = '0; e_rb = '0; e_ef = '0; e_eb = '0;
  endtask

  task automatic build_test(input int len, input logic [15:0] id);
    logic [15:0] tl, pat, c;
    int unsigned s;
    for (int i = 0; i < 34; i++) fb[i] = 8'h00;
    for (int i = 0; i < 6; i++) fb[i] = 8'h02 + 8'(i);
    for (int i = 6; i < 12; i++) fb[i] = 8'hA0 + 8'(i);
    fb[12] = 8'h08; fb[13] = 8'h00; fb[14] = 8'h45; fb[15] = TOS;
    tl = 16'(len - 14);
    fb[16] = tl[15:8]; fb[17] = tl[7:0];
    fb[18] = id[15:8]; fb[19] = id[7:0];
    fb[20] = 8'h40; fb[22] = 8'd64; fb[23] = PROTO;
    fb[26] = 8'd10; fb[29] = 8'd1; fb[30] = 8'd10; fb[33] = 8'd2;
    s = 0;
    for (int j = 0; j < 10; j++) s += {16'h0, fb[14+2*j], fb[15+2*j]};
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    c = ~s[15:0];
    fb[24] = c[15:8]; fb[25] = c[7:0];
    for (int i = 34; i < len; i++) begin
      pat = id;
      for (int n = 0; n < i / KW; n++) pat = lstep(pat);
      fb[i] = (i % 2 == 1) ? pat[15:8] : pat[7:0];
    end
  endtask

  task automatic build_arp(input int len);
    for (int i = 0; i < len; i++) fb[i] = 8'(i * 7 + 3);
    fb[12] = 8'h08; fb[13] = 8'h06;
  endtask

  task automatic get_beat(input int len, input int b, output logic [DW-1:0] d,
                          output logic [KW-1:0] k, output logic l);
    d = '0; k = '0;
    for (int p = 0; p < KW; p++) begin
      if (b * KW + p < len) begin
        d[8*p +: 8] = fb[b*KW+p];
        k[p] = 1'b1;
      end
    end
    l = ((b + 1) * KW >= len);
    if (l) k = k & last_kmask;
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                            input logic l);
    int n;
    logic got;
    axis_s_data = d; axis_s_keep = k; axis_s_last = l;
    axis_s_user = user_inj; axis_s_valid = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      got = axis_s_ready;
      tick();
      n++;
    end
    axis_s_valid = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL beat_timeout s_ready low for %0d cycles, required 1", n);
    end
  endtask

  task automatic send_beats(input int len, input bit pass, input int b0,
                            input int b1, input bit start_last);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic l;
    for (int b = b0; b <= b1; b++) begin
      get_beat(len, b, d, k, l);
      if (pass) sb.push_back('{d, k, l, user_inj, 3'd5});
      if (start_last && l) start = 1'b1;
      drive_beat(d, k, l);
      start = 1'b0;
    end
  endtask

  task automatic test_reset();
    build_arp(64);
    axis_s_data = '1; axis_s_keep = '1; axis_s_last = 1'b1;
    axis_s_valid = 1'b1; axis_m_ready = 1'b1; rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({ready, axis_m_valid, axis_s_ready} !== 3'b100 ||
        {recv_frames, recv_bytes, err_frames, err_bytes} !== '0) begin
      errors++;
      $display("FAIL reset got ready/mv/sr=%b%b%b cnt=%0d/%0d/%0d/%0d exp 100 0/0/0/0",
               ready, axis_m_valid, axis_s_ready,
               recv_frames, recv_bytes, err_frames, err_bytes);
    end
    axis_s_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_good();
    int m0;
    m0 = m_seen;
    pulse_start();
    build_test(100, 16'h1234);
    send_beats(100, 0, 0, 1, 0);
    e_rf = 1; e_rb = 100;
    checks++;
    if ({recv_frames, recv_bytes, err_frames, err_bytes} !== {e_rf, e_rb, e_ef, e_eb}) begin
      errors++;
      $display("FAIL good_100 got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
               recv_frames, recv_bytes, err_frames, err_bytes, e_rf, e_rb, e_ef, e_eb);
    end
    build_test(64, 16'hBEEF);
    send_beats(64, 0, 0, 0, 0);
    e_rf = 2; e_rb = 164;
    checks++;
    if ({recv_frames, recv_bytes, err_frames, err_bytes} !== {e_rf, e_rb, e_ef, e_eb}) begin
      errors++;
      $display("FAIL good_single got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
               recv_frames, recv_bytes, err_frames, err_bytes, e_rf, e_rb, e_ef, e_eb);
    end
    checks++;
    if (m_seen !== m0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL good_drop got m_beats=%0d ready=%b exp m_beats=%0d ready=0",
               m_seen, ready, m0);
    end
  endtask

  task automatic test_bad_payload();
    pulse_start();
    build_test(100, 16'h1234);
    fb[40] = fb[40] ^ 8'h01;
    send_beats(100, 0, 0, 1, 0);
    e_ef = 1; e_eb = 100;
    checks++;
    if ({recv_frames, recv_bytes, err_frames, err_bytes} !== {e_rf, e_rb, e_ef, e_eb}) begin
      errors++;
      $display("FAIL bad_payload got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
               recv_frames, recv_bytes, err_frames, err_bytes, e_rf, e_rb, e_ef, e_eb);
    end
  endtask

  task automatic test_bad_header();
    pulse_start();
    build_test(100, 16'h0F0F);
    fb[25] = fb[25] ^ 8'h10;
    send_beats(100, 0, 0, 1, 0);
    e_ef = 1; e_eb = 100;
    checks++;
    if ({recv_frames, recv_bytes, err_frames, err_bytes} !== {e_rf, e_rb, e_ef, e_eb}) begin
      errors++;
      $display("FAIL bad_csum got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
               recv_frames, recv_bytes, err_frames, err_bytes, e_rf, e_rb, e_ef, e_eb);
    end
    build_test(100, 16'h0F0F);
    user_inj = KW'(1) << 9;
    send_beats(100, 0, 0, 1, 0);
    user_inj = '0;
    e_ef = 2; e_eb = 200;
    checks++;
    if ({recv_frames, recv_bytes, err_frames, err_bytes} !== {e_rf, e_rb, e_ef, e_eb}) begin
      errors++;
      $display("FAIL bad_user got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
               recv_frames, recv_bytes, err_frames, err_bytes, e_rf, e_rb, e_ef, e_eb);
    end
    last_kmask = ~(KW'(1) << 3);
    send_beats(100, 0, 0, 1, 0);
    last_kmask = '1;
    e_ef = 3; e_eb = 299;
    checks++;
    if ({recv_frames, recv_bytes, err_frames, err_bytes} !== {e_rf, e_rb, e_ef, e_eb}) begin
      errors++;
      $display("FAIL bad_keep got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
               recv_frames, recv_bytes, err_frames, err_bytes, e_rf, e_rb, e_ef, e_eb);
    end
  endtask

  task automatic test_passthru();
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic l;
    int m0;
    m0 = m_seen;
    build_arp(100);
    get_beat(100, 0, d, k, l);
    sb.push_back('{d, k, l, '0, 3'd5});
    axis_s_data = d; axis_s_keep = k; axis_s_last = l; axis_s_valid = 1'b1;
    axis_m_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (axis_s_ready !== 1'b0 || axis_m_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got s_ready=%b m_valid=%b exp 0 1",
                 c, axis_s_ready, axis_m_valid);
      end
    end
    tick();
    axis_m_ready = 1'b1;
    drive_beat(d, k, l);
    send_beats(100, 1, 1, 1, 0);
    checks++;
    if (m_seen !== m0 + 2 || sb.size() != 0 ||
        {recv_frames, recv_bytes, err_frames, err_bytes} !== {e_rf, e_rb, e_ef, e_eb}) begin
      errors++;
      $display("FAIL passthru got m_beats=%0d pending=%0d err_f=%0d exp m_beats=%0d pending=0 err_f=%0d",
               m_seen - m0, sb.size(), err_frames, 2, e_ef);
    end
  endtask

  task automatic test_stop_drain();
    int m0;
    pulse_start();
    build_test(200, 16'hACE1);
    send_beats(200, 0, 0, 0, 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_state got ready=%b exp 0", ready);
    end
    send_beats(200, 0, 1, 3, 0);
    e_rf = 1; e_rb = 200;
    checks++;
    if ({recv_frames, recv_bytes, err_frames, err_bytes} !== {e_rf, e_rb, e_ef, e_eb} ||
        ready !== 1'b1) begin
      errors++;
      $display("FAIL drain_count got %0d/%0d/%0d/%0d ready=%b exp %0d/%0d/%0d/%0d ready=1",
               recv_frames, recv_bytes, err_frames, err_bytes, ready, e_rf, e_rb, e_ef, e_eb);
    end
    m0 = m_seen;
    build_test(100, 16'h5555);
    send_beats(100, 0, 0, 1, 0);
    checks++;
    if ({recv_frames, recv_bytes, err_frames, err_bytes} !== {e_rf, e_rb, e_ef, e_eb} ||
        m_seen !== m0) begin
      errors++;
      $display("FAIL idle_frame got %0d/%0d/%0d/%0d m_beats=%0d exp %0d/%0d/%0d/%0d m_beats=0",
               recv_frames, recv_bytes, err_frames, err_bytes, m_seen - m0, e_rf, e_rb, e_ef, e_eb);
    end
  endtask

  task automatic test_start_last();
    pulse_start();
    build_test(100, 16'h2468);
    send_beats(100, 0, 0, 1, 0);
    e_rf = 1; e_rb = 100;
    checks++;
    if ({recv_frames, recv_bytes, err_frames, err_bytes} !== {e_rf, e_rb, e_ef, e_eb}) begin
      errors++;
      $display("FAIL pre_start got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
               recv_frames, recv_bytes, err_frames, err_bytes, e_rf, e_rb, e_ef, e_eb);
    end
    send_beats(100, 0, 0, 1, 1);
    e_rf = 0; e_rb = 0;
    checks++;
    if ({recv_frames, recv_bytes, err_frames, err_bytes} !== '0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL start_wins got %0d/%0d/%0d/%0d ready=%b exp 0/0/0/0 ready=0",
               recv_frames, recv_bytes, err_frames, err_bytes, ready);
    end
    send_beats(100, 0, 0, 1, 0);
    e_rf = 1; e_rb = 100;
    checks++;
    if ({recv_frames, recv_bytes, err_frames, err_bytes} !== {e_rf, e_rb, e_ef, e_eb}) begin
      errors++;
      $display("FAIL run_after_start got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
               recv_frames, recv_bytes, err_frames, err_bytes, e_rf, e_rb, e_ef, e_eb);
    end
  endtask

  task automatic test_len_long();
    pulse_start();
    build_test(1600, 16'h1357);
    send_beats(1600, 0, 0, 24, 0);
`ifdef FRAME_CHECKER_LEN_CHECK_EN
    e_ef = 1; e_eb = 1600;
`else
    e_rf = 1; e_rb = 1600;
`endif
    checks++;
    if ({recv_frames, recv_bytes, err_frames, err_bytes} !== {e_rf, e_rb, e_ef, e_eb}) begin
      errors++;
      $display("FAIL len_1600 got %0d/%0d/%0d/%0d exp %0d/%0d/%0d/%0d",
               recv_frames, recv_bytes, err_frames, err_bytes, e_rf, e_rb, e_ef, e_eb);
    end
  endtask

  initial begin
    e_rf = '0; e_rb = '0; e_ef = '0; e_eb = '0;
    test_reset();
    test_good();
    test_bad_payload();
    test_bad_header();
    test_passthru();
    test_stop_drain();
    test_start_last();
    test_len_long();
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
